wallace_csa_pipe: RTL
=====================

Name: wallace_csa_pipe

Overview:
- Pipelined, handshaked 16x16 unsigned partial-product generator and carry-save (Wallace/3:2) reduction stage of the multiplier.
- Directly upstream of the final carry-propagate adder stage; delivers two redundant rows (sum row, carry row) whose sum is the product.
- Two register stages, one product per cycle sustained, full backpressure support.

Parameters:
- WIDTH, 16, operand width; output rows are 2*WIDTH bits; only 16 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present on a/b
- in_ready  output  1  stage can accept a/b this cycle
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  row_s/row_c hold a valid result
- out_ready  input  1  downstream adder accepts rows this cycle
- row_s  output  2*WIDTH  carry-save sum row
- row_c  output  2*WIDTH  carry-save carry row, already weight-aligned (no further shift by consumer)

Behaviour:
- One clock (clk), synchronous active-high reset (rst); all state changes on rising clk.
- Arithmetic: (row_s + row_c) mod 2^(2*WIDTH) == a*b for the accepted pair; product always fits in 2*WIDTH bits; carries out of bit 2*WIDTH-1 discarded inside reduction.
- Partial products: pp[i] = (b[i] ? a : 0) << i, i = 0..WIDTH-1, unsigned, zero-extended.
- Stage 1 (combinational, registered into S1): 3:2 CSA layers reduce 16 rows -> 11 -> 8 -> 6 -> 4; S1 holds 4 rows plus s1_valid.
- Stage 2 (combinational, registered into S2): 4 -> 3 -> 2; S2 drives row_s/row_c; out_valid = s2_valid.
- Handshake, per cycle:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; no combinational path from in_valid to in_ready)
- Transfer occurs when valid && ready on the same cycle at either boundary.
- S1 load: if s1_adv, S1 <= stage-1 result of a/b and s1_valid <= in_valid && in_ready.
- S2 load: if s2_adv, S2 <= stage-2 result of S1 rows and s2_valid <= s1_valid.
- Latency: pair accepted at edge N appears with out_valid at edge N+2 when out_ready is held high.
- Throughput: one pair per cycle with out_ready continuously high.
- Stall: out_valid && !out_ready freezes S2; row_s/row_c are stable and unchanged until accepted. If S1 is also valid, S1 freezes and in_ready=0. If S1 is empty, one more pair may be accepted into S1 (bubble collapse).
- Simultaneous accept at output and input with both stages full: all stages advance; no result dropped or duplicated.
- Ordering: results leave strictly in acceptance order.
- Reset (any time, including mid-operation): s1_valid=0, s2_valid=0, out_valid=0, row_s=0, row_c=0, S1 rows=0. In-flight pairs are discarded. in_ready=1 on the first cycle after reset deasserts.
- Unused data inputs (in_valid=0) never change stage contents; X on a/b with in_valid=0 must not propagate to outputs.

Test Plan:
- a=0xFFFF, b=0xFFFF, in_valid=1 one cycle, out_ready=1 -> out_valid high exactly 2 cycles later; (row_s+row_c) mod 2^32 = 0xFFFE0001; out_valid low the next cycle.
- Back-to-back pairs (0,0x1234), (1,1), (0x00FF,0x0100), (0x8000,2) on consecutive cycles, out_ready=1 -> four consecutive out_valid cycles, sums 0x0, 0x1, 0xFF00, 0x10000, in order.
- Backpressure: out_ready=0 while feeding 3 pairs -> in_ready drops after S1 and S2 are full (2 accepted); row_s/row_c constant while stalled; raise out_ready -> remaining pair accepted; all 3 results in order, none lost or duplicated.
- Bubble collapse: S2 full and stalled, S1 empty -> in_ready=1, one pair accepted; next cycle in_ready=0.
- Reset mid-flight: assert rst with both stages valid -> next cycle out_valid=0, row_s=row_c=0, in_ready=1; no stale result emerges afterwards.
- Random: 10,000 random a/b with random in_valid/out_ready -> every output pair sums to the scoreboard product, in order.

Source files
------------

// File: rtl/wallace_csa_pipe.sv
// Two-stage 16x16 unsigned partial-product generator with 3:2 carry-save reduction.
// Emits a redundant sum/carry row pair per product under a valid/ready handshake.
module wallace_csa_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] row_s,
  output logic [2*WIDTH-1:0] row_c
);

  localparam int PW = 2 * WIDTH;

  typedef logic [PW-1:0] row_t;

  function automatic row_t csa_sum(input row_t x, input row_t y, input row_t z);
    return x ^ y ^ z;
  endfunction

  // Carry row is pre-shifted so every row shares the same weight; the top carry drops out.
  function automatic row_t csa_car(input row_t x, input row_t y, input row_t z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  row_t pp [16];
  row_t l1 [11];
  row_t l2 [8];
  row_t l3 [6];
  row_t l4 [4];
  row_t m1 [3];
  row_t m2 [2];

  logic s1_valid_q, s1_valid_d;
  row_t s1_rows_q [4];
  row_t s1_rows_d [4];
  logic s2_valid_q, s2_valid_d;
  row_t s2_s_q, s2_s_d;
  row_t s2_c_q, s2_c_d;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pp[i] = b[i] ? (row_t'(a) << i) : '0;
    end
  end

  // Stage 1 reduction: 16 -> 11 -> 8 -> 6 -> 4 rows.
  always_comb begin
    for (int g = 0; g < 5; g++) begin
      l1[2*g]   = csa_sum(pp[3*g], pp[3*g+1], pp[3*g+2]);
      l1[2*g+1] = csa_car(pp[3*g], pp[3*g+1], pp[3*g+2]);
    end
    l1[10] = pp[15];

    for (int g = 0; g < 3; g++) begin
      l2[2*g]   = csa_sum(l1[3*g], l1[3*g+1], l1[3*g+2]);
      l2[2*g+1] = csa_car(l1[3*g], l1[3*g+1], l1[3*g+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];

    for (int g = 0; g < 2; g++) begin
      l3[2*g]   = csa_sum(l2[3*g], l2[3*g+1], l2[3*g+2]);
      l3[2*g+1] = csa_car(l2[3*g], l2[3*g+1], l2[3*g+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];

    for (int g = 0; g < 2; g++) begin
      l4[2*g]   = csa_sum(l3[3*g], l3[3*g+1], l3[3*g+2]);
      l4[2*g+1] = csa_car(l3[3*g], l3[3*g+1], l3[3*g+2]);
    end
  end

  // Stage 2 reduction: 4 -> 3 -> 2 rows.
  always_comb begin
    m1[0] = csa_sum(s1_rows_q[0], s1_rows_q[1], s1_rows_q[2]);
    m1[1] = csa_car(s1_rows_q[0], s1_rows_q[1], s1_rows_q[2]);
    m1[2] = s1_rows_q[3];
    m2[0] = csa_sum(m1[0], m1[1], m1[2]);
    m2[1] = csa_car(m1[0], m1[1], m1[2]);
  end

  always_comb begin
    s2_adv  = !s2_valid_q || out_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    in_fire = in_valid && s1_adv;
  end

  // Data registers only load on a real transfer, so idle (possibly X) operands never reach the rows.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rows_d  = s1_rows_q;
    s2_valid_d = s2_valid_q;
    s2_s_d     = s2_s_q;
    s2_c_d     = s2_c_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_fire) begin
        s1_rows_d = l4;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_s_d = m2[0];
        s2_c_d = m2[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1_rows_q[i] <= '0;
      end
      s2_valid_q <= 1'b0;
      s2_s_q     <= '0;
      s2_c_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      for (int i = 0; i < 4; i++) begin
        s1_rows_q[i] <= s1_rows_d[i];
      end
      s2_valid_q <= s2_valid_d;
      s2_s_q     <= s2_s_d;
      s2_c_q     <= s2_c_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign row_s     = s2_s_q;
  assign row_c     = s2_c_q;

endmodule
